// File: rtl/apb_ral_slave.sv
`timescale 1ns/1ps
// apb_ral_slave: APB3 register block (CTRL, DATA0, DATA1, COUNT). Optional pslverr with APB_SLV_PSLVERR_EN.
// Latency: read data registered on the setup edge (valid in access cycle); writes commit on the access edge.
// Backpressure: none (no pready); every transfer is exactly one setup plus one access cycle.
module apb_ral_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] DATA1_RST = 32'hA5A5_A5A5
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
`ifdef APB_SLV_PSLVERR_EN
    output logic        pslverr,
`endif
    output logic [31:0] prdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [31:0] data0_q, data0_d;
    logic [31:0] data1_q, data1_d;
    logic [31:0] count_q, count_d;
    logic [31:0] prdata_q, prdata_d;

    logic        setup_edge;
    logic        mapped;
    logic        wr_commit;
    logic [1:0]  reg_sel;
    logic [31:0] rd_val;

    assign setup_edge = psel & ~penable;
    assign mapped     = (paddr[31:4] == BASE_ADDR[31:4]) && (paddr[1:0] == 2'b00);
    assign reg_sel    = paddr[3:2];
    // Only the first access edge after a setup writes; extended or setup-less accesses do not.
    assign wr_commit  = (state_q == ST_SETUP) & psel & penable & pwrite & mapped;
    assign prdata     = prdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (psel && !penable) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (!psel)        state_d = ST_IDLE;
                else if (penable) state_d = ST_ACCESS;
                else              state_d = ST_SETUP;
            end
            ST_ACCESS: begin
                if (!psel)         state_d = ST_IDLE;
                else if (!penable) state_d = ST_SETUP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        if (mapped) begin
            unique case (reg_sel)
                2'd0:    rd_val = {24'h0, ctrl_q};
                2'd1:    rd_val = data0_q;
                2'd2:    rd_val = data1_q;
                default: rd_val = count_q;
            endcase
        end
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        count_d  = ctrl_q[0] ? count_q + 32'd1 : count_q;
        prdata_d = prdata_q;
        if (setup_edge && !pwrite) prdata_d = rd_val;
        if (wr_commit) begin
            unique case (reg_sel)
                2'd0: begin
                    // CNT_CLR is a pulse: it beats the increment and is never stored.
                    ctrl_d = {pwdata[7:2], 1'b0, pwdata[0]};
                    if (pwdata[1]) count_d = '0;
                end
                2'd1:    data0_d = pwdata;
                2'd2:    data1_d = pwdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            data0_q  <= '0;
            data1_q  <= DATA1_RST;
            count_q  <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            count_q  <= count_d;
            prdata_q <= prdata_d;
        end
    end

`ifdef APB_SLV_PSLVERR_EN
    logic pslverr_q, pslverr_d;

    // Re-evaluated on every setup edge, dropped on any other edge.
    assign pslverr_d = setup_edge & (~mapped | (pwrite & (reg_sel == 2'd3)));
    assign pslverr   = pslverr_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) pslverr_q <= 1'b0;
        else          pslverr_q <= pslverr_d;
    end
`endif

endmodule

// File: tb/tb_apb_ral_slave.sv
`timescale 1ns/1ps
// tb_apb_ral_slave: directed APB transfers against a transaction-level register model,
// checked every cycle plus hand-computed readback literals.
module tb_apb_ral_slave;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] D1R  = 32'hA5A5_A5A5;

    logic        pclk    = 1'b0;
    logic        presetn = 1'b0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] paddr   = '0;
    logic [31:0] pwdata  = '0;
    logic [31:0] prdata;
    logic        pslverr;
`ifndef APB_SLV_PSLVERR_EN
    assign pslverr = 1'b0;
`endif

    // Driver's statement that this access edge legitimately completes a write.
    logic        wr_intent = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    apb_ral_slave #(.BASE_ADDR(BASE), .DATA1_RST(D1R)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
`ifdef APB_SLV_PSLVERR_EN
        .pslverr (pslverr),
`endif
        .prdata  (prdata)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- register model ----------------
    logic [7:0]  m_ctrl;
    logic [31:0] m_data0, m_data1, m_count, m_prdata;
    logic        m_perr;
    logic        model_live = 1'b0;

    function automatic logic m_mapped(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off < 32'd16) && (off % 4 == 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (!m_mapped(a)) return 32'h0;
        case (off)
            32'h0:   return {24'h0, m_ctrl};
            32'h4:   return m_data0;
            32'h8:   return m_data1;
            default: return m_count;
        endcase
    endfunction

    initial begin
        logic [31:0] next_count;
        forever begin
            @(posedge pclk or negedge presetn);
            if (!presetn) begin
                m_ctrl = 8'h0; m_data0 = 32'h0; m_data1 = D1R;
                m_count = 32'h0; m_prdata = 32'h0; m_perr = 1'b0;
                model_live = 1'b1;
            end else if (pclk) begin
                if (psel && !penable) begin
                    if (!pwrite) m_prdata = m_read(paddr);
                    m_perr = !m_mapped(paddr) || (pwrite && (paddr - BASE == 32'hC));
                end else begin
                    m_perr = 1'b0;
                end
                next_count = m_ctrl[0] ? m_count + 1 : m_count;
                if (wr_intent && m_mapped(paddr)) begin
                    case (paddr - BASE)
                        32'h0: begin
                            if (pwdata[1]) next_count = 32'h0;
                            m_ctrl = pwdata[7:0] & 8'hFD;
                        end
                        32'h4: m_data0 = pwdata;
                        32'h8: m_data1 = pwdata;
                        default: ;
                    endcase
                end
                m_count = next_count;
            end
        end
    end

    // Per-cycle compare, sampled well after the active edge.
    initial begin
        forever begin
            @(posedge pclk);
            #2;
            if (model_live) begin
                chk("cyc_prdata", prdata, m_prdata);
`ifdef APB_SLV_PSLVERR_EN
                chk("cyc_pslverr", {31'h0, pslverr}, {31'h0, m_perr});
`endif
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            psel = 1'b0; penable = 1'b0; wr_intent = 1'b0;
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; wr_intent = 1'b0;
        @(negedge pclk);
        penable = 1'b1; wr_intent = 1'b1;
`ifdef APB_SLV_PSLVERR_EN
        chk("wr_pslverr", {31'h0, pslverr}, {31'h0, exp_err});
`else
        if (exp_err) chk("wr_silent_prdata_hold", prdata, m_prdata);
`endif
    endtask

    task automatic bus_rd(input string nm, input logic [31:0] a, input logic [31:0] exp,
                          input logic exp_err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; wr_intent = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        chk(nm, prdata, exp);
`ifdef APB_SLV_PSLVERR_EN
        chk({nm, "_err"}, {31'h0, pslverr}, {31'h0, exp_err});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        chk("reset_prdata", prdata, 32'h0);
        @(negedge pclk);
        presetn = 1'b1;
        bus_rd("rst_ctrl",  BASE + 32'h0, 32'h0, 1'b0);
        bus_rd("rst_data0", BASE + 32'h4, 32'h0, 1'b0);
        bus_rd("rst_data1", BASE + 32'h8, D1R, 1'b0);
        bus_rd("rst_count", BASE + 32'hC, 32'h0, 1'b0);

        // Back-to-back write/read and CTRL masking
        bus_wr(BASE + 32'h4, 32'hCAFE_F00D, 1'b0);
        bus_rd("data0_b2b", BASE + 32'h4, 32'hCAFE_F00D, 1'b0);
        bus_wr(BASE + 32'h0, 32'hFFFF_FFFF, 1'b0);
        bus_rd("ctrl_mask", BASE + 32'h0, 32'h0000_00FD, 1'b0);
        bus_wr(BASE + 32'h0, 32'h0000_0002, 1'b0);
        bus_rd("ctrl_clr",  BASE + 32'h0, 32'h0, 1'b0);
        bus_rd("count_clr", BASE + 32'hC, 32'h0, 1'b0);

        // Counter: enable, clear-with-enable, ignored write, freeze
        bus_wr(BASE + 32'h0, 32'h1, 1'b0);
        idle(10);
        bus_rd("count_10", BASE + 32'hC, 32'd10, 1'b0);
        bus_wr(BASE + 32'h0, 32'h3, 1'b0);
        bus_rd("count_restart", BASE + 32'hC, 32'd0, 1'b0);
        bus_wr(BASE + 32'hC, 32'h1234, 1'b1);
        bus_rd("count_ro", BASE + 32'hC, 32'd4, 1'b0);
        bus_wr(BASE + 32'h0, 32'h0, 1'b0);
        idle(3);
        bus_rd("count_frozen", BASE + 32'hC, 32'd8, 1'b0);

        // Unmapped and misaligned reads
        bus_rd("unmapped_10",  BASE + 32'h10, 32'h0, 1'b1);
        bus_rd("misalign_05",  BASE + 32'h05, 32'h0, 1'b1);
        bus_rd("data0_intact", BASE + 32'h4, 32'hCAFE_F00D, 1'b0);

        // Access without setup must not write
        idle(1);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = BASE + 32'h4;
        pwdata = 32'hDEAD_BEEF; wr_intent = 1'b0;
        idle(1);
        bus_rd("no_setup_wr", BASE + 32'h4, 32'hCAFE_F00D, 1'b0);

        // Extended access: penable held 3 cycles, only the first edge writes
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h4;
        pwdata = 32'h1111_1111; wr_intent = 1'b0;
        @(negedge pclk);
        penable = 1'b1; wr_intent = 1'b1;
        @(negedge pclk);
        pwdata = 32'h2222_2222; wr_intent = 1'b0;
        @(negedge pclk);
        pwdata = 32'h3333_3333;
        idle(1);
        bus_rd("ext_single_wr", BASE + 32'h4, 32'h1111_1111, 1'b0);

        // Reset during the access cycle of a DATA1 write
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h8;
        pwdata = 32'h1234_5678; wr_intent = 1'b0;
        @(negedge pclk);
        penable = 1'b1; wr_intent = 1'b1;
        #2;
        presetn = 1'b0;
        #1;
        chk("async_rst_prdata", prdata, 32'h0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; wr_intent = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        bus_rd("data1_after_rst", BASE + 32'h8, D1R, 1'b0);
        bus_rd("data0_after_rst", BASE + 32'h4, 32'h0, 1'b0);
        bus_rd("ctrl_after_rst",  BASE + 32'h0, 32'h0, 1'b0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_ral_slave.md
# apb_ral_slave

APB completer (slave) register block that answers the driver on the `psel/penable/pwrite/paddr/pwdata/prdata` bus used by the RAL environment. It holds four 32-bit registers: control, two scratch/data registers and a free-running event counter. It is the DUT that the RAL model mirrors. It follows zero-wait-state APB3-without-`pready` semantics: every transfer is exactly one setup cycle plus one access cycle.

## Interface
- `BASE_ADDR`, default `32'h0000_0000`: base of the 16-byte register window; bits [3:0] must be 0.
- `DATA1_RST`, default `32'hA5A5_A5A5`: reset value of DATA1.
- `pclk` input, 1: bus clock; all state updates on its rising edge.
- `presetn` input, 1: reset. Asynchronous, active-low.
- `psel` input, 1: select.
- `penable` input, 1: access phase.
- `pwrite` input, 1: 1 = write, 0 = read.
- `paddr` input, 32: byte address.
- `pwdata` input, 32: write data.
- `prdata` output, 32: read data, registered.

## Operation
Register map (offset from `BASE_ADDR`):
- 0x00 CTRL, RW, reset 0.
  - Bits [7:0] are implemented; [31:8] read 0.
  - Bit0 = CNT_EN.
  - Bit1 = CNT_CLR. Writing 1 clears COUNT. The bit is self-clearing, is never stored and always reads 0.
- 0x04 DATA0, RW, 32 bits, reset 0.
- 0x08 DATA1, RW, 32 bits, reset `DATA1_RST`.
- 0x0C COUNT, RO, reset 0.
  - Increments by 1 on every `pclk` edge while CNT_EN=1.
  - Wraps 0xFFFF_FFFF -> 0.
  - Writes are ignored.

Address decode:
- Mapped when `paddr[31:4]==BASE_ADDR[31:4]` and `paddr[1:0]==0`.
- Register select is `paddr[3:2]`.
- Anything else is unmapped: reads return 0 and writes are ignored.

Phase FSM (`state`), updated on each edge from sampled `psel/penable`:
- IDLE:
  - `psel & !penable` -> SETUP.
  - `psel & penable` (no setup) -> protocol violation. Stay IDLE; no read or write action.
- SETUP:
  - `psel & penable` -> ACCESS. This edge completes the transfer.
  - `psel & !penable` -> SETUP, treated as a new setup.
  - `!psel` -> IDLE, transfer abandoned.
- ACCESS:
  - `psel & !penable` -> SETUP (back-to-back transfer).
  - `!psel` -> IDLE.
  - `psel & penable` -> stay ACCESS. This is an extended access and performs no second write.

## Timing
- Reset (async assert, sync release by system):
  - `prdata`=0, CTRL=0, DATA0=0, DATA1=`DATA1_RST`, COUNT=0, `state`=IDLE.
  - A transfer in flight when reset asserts is lost; no partial write occurs.
- Read:
  - On the edge sampling `psel & !penable & !pwrite`, `prdata` <= decoded register value.
  - `prdata` is therefore valid throughout the access cycle.
  - COUNT returns its value at that setup edge.
  - `prdata` holds its last value at all other times.
- Write:
  - Commits on the edge where `state==SETUP & psel & penable & pwrite`, using `pwdata` and `paddr` sampled at that edge.
  - The new value is visible to a read whose setup edge is the next edge or later.
- Counter:
  - A CNT_CLR=1 write wins over increment on the same edge: COUNT=0.
  - Writing CTRL=0x3 gives COUNT=0 at that edge, then +1 on each following edge.
  - Writing CNT_EN=0 freezes COUNT from the following edge.
- Minimum transfer is 2 cycles; back-to-back transfers need no idle cycle.

## Configuration
- `APB_SLV_PSLVERR_EN` defined:
  - Adds output `pslverr` (1 bit, registered, reset 0).
  - Set on the setup edge for: unmapped address, misaligned `paddr[1:0]!=0`, or a write to COUNT.
  - Valid during the access cycle; cleared on the next edge unless another setup re-evaluates it.
  - Erroring writes are still ignored.
- Undefined:
  - No `pslverr` port.
  - The same accesses complete silently: reads return 0, writes are dropped.

## Test plan
- Reset, then read 0x00/0x04/0x08/0x0C -> `prdata` = 0, 0, 0xA5A5_A5A5, 0.
- Write 0x04=0xCAFE_F00D, then read back-to-back with no idle -> 0xCAFE_F00D; write 0x00=0xFFFF_FFFF, read -> 0x0000_00FD.
- Write CTRL=0x1, idle 10 cycles, read COUNT -> 10 plus the cycles to the setup edge (exact count checked by the scoreboard); write CTRL=0x3, read -> small value restarting from 0; write 0x0C=0x1234 -> COUNT unaffected.
- Read 0x10 and 0x05 -> `prdata`=0 (with macro: `pslverr`=1 in access cycle); write 0x0C -> `pslverr`=1.
- `psel & penable` asserted with no setup phase, `pwrite`=1, addr 0x04 -> DATA0 unchanged; `penable` held 3 cycles -> single write only.
- Assert `presetn` low during the access cycle of a write to DATA1 -> DATA1 reads `DATA1_RST` after release.
